// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_t;

  localparam int unsigned NREQ = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select: the first requester after i_last wins,
// with i_last itself lowest priority.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    // Walk from farthest to nearest so the nearest requester after i_last is kept.
    for (int off = N; off >= 1; off--) begin
      int cand;
      cand = (int'(i_last) + off) % N;
      if (i_req[cand]) begin
        o_valid = 1'b1;
        o_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Two-requester round-robin arbiter with held one-hot grant, bounded tenure and a
// single dead cycle between grants.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            owner,
  output logic            timeout
);

  arb_state_t       r_state;
  logic [NREQ-1:0]  r_grant;
  logic             r_busy;
  logic             r_owner;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  arb_state_t       w_state_nxt;
  logic [NREQ-1:0]  w_grant_nxt;
  logic             w_owner_nxt;
  logic             w_last_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_timeout_nxt;

  logic             w_pick_valid;
  logic             w_pick_idx;
  logic             w_release;
  logic             w_limit;

  rr_pick #(
    .N (NREQ),
    .IW(1)
  ) u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_valid(w_pick_valid),
    .o_idx  (w_pick_idx)
  );

  assign w_release = done || !req[r_owner];
  assign w_limit   = (r_cnt == CNT_W'(HOLD_MAX));

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE, GAP: begin
        if (w_pick_valid) begin
          w_state_nxt = GRANT;
          w_grant_nxt = NREQ'(1) << w_pick_idx;
          w_owner_nxt = w_pick_idx;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end
      end
      GRANT: begin
        // Normal release outranks the limit, so a coincident done never flags timeout.
        if (w_release || w_limit) begin
          w_state_nxt   = GAP;
          w_grant_nxt   = '0;
          w_last_nxt    = r_owner;
          w_timeout_nxt = !w_release;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign grant   = r_grant;
  assign busy    = r_busy;
  assign owner   = r_owner;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: a behavioural model predicts each cycle's
// outputs into a queue and a negedge monitor compares them against the DUT.
module tb_rr_grant_arbiter;

  localparam int unsigned HM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic       done = 1'b0;
  logic [1:0] grant;
  logic       busy;
  logic       owner;
  logic       timeout;

  typedef struct packed {
    logic [1:0] grant;
    logic       busy;
    logic       owner;
    logic       timeout;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  rr_grant_arbiter #(
    .HOLD_MAX(HM)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .done   (done),
    .grant  (grant),
    .busy   (busy),
    .owner  (owner),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: "held" tracks an ongoing tenure, len its length so far.
  bit   m_held = 0;
  bit   m_gap = 0;
  logic m_owner = 1'b0;
  logic m_last = 1'b1;
  int   m_len = 0;
  bit   m_tmo = 0;

  always @(posedge clk) begin
    exp_t e;
    bit rel;
    bit lim;
    m_tmo = 0;
    if (reset) begin
      m_held = 0; m_gap = 0; m_owner = 1'b0; m_last = 1'b1; m_len = 0;
    end else if (m_held) begin
      rel = done || !req[m_owner];
      lim = (m_len == HM);
      if (rel || lim) begin
        m_last = m_owner;
        m_held = 0;
        m_gap  = 1;
        m_tmo  = !rel;
      end else begin
        m_len++;
      end
    end else begin
      m_gap = 0;
      if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? !m_last : req[1];
        m_len   = 1;
        m_held  = 1;
      end
    end
    e.grant   = m_held ? (2'b01 << m_owner) : 2'b00;
    e.busy    = m_held || m_gap;
    e.owner   = m_owner;
    e.timeout = m_tmo;
    q.push_back(e);
  end

  function automatic void chk(string nm, logic [1:0] act, logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0b expected %0b", nm, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = q.pop_front();
      chk("grant",   grant,            e.grant);
      chk("busy",    {1'b0, busy},     {1'b0, e.busy});
      chk("owner",   {1'b0, owner},    {1'b0, e.owner});
      chk("timeout", {1'b0, timeout},  {1'b0, e.timeout});
    end
  end

  task automatic step(input logic r, input logic [1:0] rq, input logic d);
    @(posedge clk);
    #1;
    reset = r;
    req   = rq;
    done  = d;
  endtask

  initial begin
    logic [1:0] rq;
    step(1, 2'b00, 0);
    step(1, 2'b00, 0);
    // Single requester released by done, then idle.
    for (int i = 0; i < 3; i++) step(0, 2'b01, 0);
    step(0, 2'b01, 1);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0);
    // Tie held, done pulsed every fourth cycle.
    for (int i = 0; i < 24; i++) step(0, 2'b11, (i % 4) == 2);
    for (int i = 0; i < 2; i++) step(0, 2'b00, 0);
    // Timeout on a lone requester.
    for (int i = 0; i < 14; i++) step(0, 2'b10, 0);
    for (int i = 0; i < 2; i++) step(0, 2'b00, 0);
    // Owner withdrawal, then non-owner noise during a tenure.
    for (int i = 0; i < 2; i++) step(0, 2'b01, 0);
    step(0, 2'b00, 0);
    step(0, 2'b00, 0);
    step(0, 2'b01, 0);
    for (int i = 0; i < 4; i++) step(0, (i % 2) ? 2'b01 : 2'b11, 0);
    for (int i = 0; i < 2; i++) step(0, 2'b00, 0);
    // done coincides with the tenure limit, then done while idle.
    for (int i = 0; i < 4; i++) step(0, 2'b01, 0);
    step(0, 2'b01, 1);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 1);
    // Reset in the second grant cycle, then tie goes to requester 0.
    step(0, 2'b10, 0);
    step(0, 2'b10, 0);
    step(1, 2'b10, 0);
    for (int i = 0; i < 6; i++) step(0, 2'b11, 0);
    // Randomised traffic with sticky requests.
    rq = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) rq[0] = ~rq[0];
      if ($urandom_range(5) == 0) rq[1] = ~rq[1];
      step($urandom_range(199) == 0, rq, $urandom_range(3) == 0);
    end
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
